// File: rtl/sparse_pkg.sv
// Purpose : shared widths, FSM state encoding and frame-size helper for the sparse encoder.
// Latency : n/a (package).
// Backpressure: n/a (package).
package sparse_pkg;

  localparam int COL_LENGTH         = 8;
  localparam int WORD_LENGTH        = 8;
  localparam int DOUBLE_WORD_LENGTH = 16;
  localparam int IMAGE_SIZE         = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } enc_state_t;

  // Number of pixels in one square frame.
  function automatic int frame_pixels(input int side);
    return side * side;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Purpose : raster-order (col fastest) position counter with frame first/last flags.
// Latency : flags are combinational on the current position; position steps on the advance edge.
// Backpressure: none; holds position while advance is low.
//
// Ports: advance steps one pixel (wrapping at frame end), clear forces (0,0),
//        col_cnt/row_cnt give the current pixel position, first/last flag (0,0)
//        and (image_size-1, image_size-1).
module raster_counter
  import sparse_pkg::*;
#(
  parameter int image_size = IMAGE_SIZE,
  parameter int col_length = COL_LENGTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  input  logic                  clear,
  output logic [col_length-1:0] col_cnt,
  output logic [col_length-1:0] row_cnt,
  output logic                  first,
  output logic                  last
);

  localparam logic [col_length-1:0] MAX_POS = col_length'(image_size - 1);

  assign first = (col_cnt == '0) && (row_cnt == '0);
  assign last  = (col_cnt == MAX_POS) && (row_cnt == MAX_POS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (clear) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (advance) begin
      if (col_cnt == MAX_POS) begin
        col_cnt <= '0;
        // Wrapping the row as well leaves the counter at (0,0) for the next frame.
        row_cnt <= (row_cnt == MAX_POS) ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sparse_feature_encoder.sv
// Purpose : compresses a raster-streamed dense frame into value/col/row lists plus a nonzero count.
// Latency : out_valid pulses 1 cycle after the edge accepting the last pixel of a frame.
// Backpressure: none; every in_valid pixel is accepted, in_valid low simply stalls the frame.
//
// Ports: in_valid/in_pixel/in_channel carry the dense stream (channel sampled on pixel (0,0));
//        busy = frame partially received; out_valid = one-cycle "frame encoded" pulse;
//        feature_value/feature_cols/feature_rows hold entry k at [(k+1)*w-1 -: w];
//        feature_valid_num = nonzero count; out_channel = channel of the frame.
module sparse_feature_encoder
  import sparse_pkg::*;
#(
  parameter int col_length         = COL_LENGTH,
  parameter int word_length        = WORD_LENGTH,
  parameter int double_word_length = DOUBLE_WORD_LENGTH,
  parameter int image_size         = IMAGE_SIZE
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  input  logic [word_length-1:0]                     in_pixel,
  input  logic [double_word_length-1:0]              in_channel,
  output logic                                       busy,
  output logic                                       out_valid,
  output logic [double_word_length-1:0]              feature_valid_num,
  output logic [image_size*image_size*word_length-1:0] feature_value,
  output logic [image_size*image_size*col_length-1:0]  feature_cols,
  output logic [image_size*image_size*col_length-1:0]  feature_rows,
  output logic [double_word_length-1:0]              out_channel
);

  localparam int PIXELS = frame_pixels(image_size);

  if (longint'(image_size) > (longint'(1) << col_length)) begin : g_bad_coord_width
    $error("image_size does not fit in col_length coordinate bits");
  end
  if (longint'(PIXELS) >= (longint'(1) << double_word_length)) begin : g_bad_count_width
    $error("frame pixel count does not fit in double_word_length bits");
  end

  enc_state_t state_q, state_d;

  logic [col_length-1:0]         col_cnt, row_cnt;
  logic                          first, last;
  logic                          nonzero;
  logic [double_word_length-1:0] wr_ptr_q, base_ptr, wr_ptr_d;
  int                            base_idx;

  logic [PIXELS*word_length-1:0] value_q;
  logic [PIXELS*col_length-1:0]  cols_q, rows_q;
  logic [double_word_length-1:0] valid_num_q, channel_q;

  // Counter is parked at (0,0) outside RUN; the clear only guards against
  // a stray non-zero position when no pixel is being accepted.
  raster_counter #(
    .image_size (image_size),
    .col_length (col_length)
  ) u_raster_counter (
    .clk     (clk),
    .rst     (rst),
    .advance (in_valid),
    .clear   ((state_q != RUN) && !in_valid),
    .col_cnt (col_cnt),
    .row_cnt (row_cnt),
    .first   (first),
    .last    (last)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = last ? DONE : RUN;
      RUN:     if (in_valid && last) state_d = DONE;
      DONE:    state_d = in_valid ? (last ? DONE : RUN) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);

  // ---------------- entry storage ----------------
  // The first pixel restarts the write pointer in the same cycle it is written.
  always_comb begin
    nonzero  = (in_pixel != '0);
    base_ptr = first ? '0 : wr_ptr_q;
    wr_ptr_d = base_ptr + double_word_length'(nonzero);
    base_idx = int'(base_ptr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q     <= '0;
      cols_q      <= '0;
      rows_q      <= '0;
      wr_ptr_q    <= '0;
      valid_num_q <= '0;
      channel_q   <= '0;
    end else if (in_valid) begin
      if (first) begin
        // Wipe the previous frame so unused entries read as zero padding.
        value_q   <= '0;
        cols_q    <= '0;
        rows_q    <= '0;
        channel_q <= in_channel;
      end
      if (nonzero) begin
        value_q[base_idx*word_length +: word_length] <= in_pixel;
        cols_q[base_idx*col_length +: col_length]    <= col_cnt;
        rows_q[base_idx*col_length +: col_length]    <= row_cnt;
      end
      wr_ptr_q <= wr_ptr_d;
      // A frame's first pixel zeroes the count unless it is also its last.
      valid_num_q <= (first && !last) ? '0 : wr_ptr_d;
    end
  end

  assign feature_value     = value_q;
  assign feature_cols      = cols_q;
  assign feature_rows      = rows_q;
  assign feature_valid_num = valid_num_q;
  assign out_channel       = channel_q;

endmodule
